antitheft_ctrl: RTL

Parametrised anti-theft controller with N door sensors, an integrated seconds countdown timer, and a siren timeout. It sits between the debounced sensor inputs and the siren driver and status LED, and is clocked from the system clock with a one-second enable strobe. It replaces the two-door FSM that relied on an external timer. New behaviour: arbitrary door count, self-timed delays, siren auto-silence, door re-open handling during the arming delay, and `reprogram` as a global top-priority override.

---
 rtl/antitheft_pkg.sv | 16 +
 rtl/antitheft_timer.sv | 29 ++
 rtl/antitheft_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/antitheft_pkg.sv
// Shared definitions for the anti-theft controller: state encoding and widths.
package antitheft_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_ALARM      = 3'd2,
    ST_DISARMED   = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5,
    ST_WAIT_TIME  = 3'd6
  } state_t;

endpackage

// File: rtl/antitheft_timer.sv
// Saturating seconds down-counter; a load on the same edge as a tick wins.
module antitheft_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count   = r_count;
  assign expired = (r_count == '0);

endmodule

// File: rtl/antitheft_ctrl.sv
// Anti-theft controller: door/ignition FSM with self-timed delays, siren
// auto-silence and an ARMED-state blinking status LED.
//
// state          | meaning
// ARMED          | watching doors, status blinks
// TRIGGERED      | door opened, countdown to alarm
// ALARM          | siren on until doors closed for T_ALARM_ON
// DISARMED       | ignition on
// WAIT_OPEN      | ignition off, waiting for driver door to open
// WAIT_CLOSE     | driver door open, waiting for it to close
// WAIT_TIME      | re-arm countdown
module antitheft_ctrl
  import antitheft_pkg::*;
#(
  parameter int NUM_DOORS      = 2,
  parameter int CNT_W          = 4,
  parameter int T_ARM_DELAY    = 6,
  parameter int T_DRIVER_DELAY = 8,
  parameter int T_PASS_DELAY   = 15,
  parameter int T_ALARM_ON     = 10,
  parameter int BLINK_DIV      = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 one_hz_enable,
  input  logic                 ignition,
  input  logic [NUM_DOORS-1:0] doors,
  input  logic                 reprogram,
  output logic                 status,
  output logic                 siren,
  output logic [STATE_W-1:0]   state_o,
  output logic [CNT_W-1:0]     time_left
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BLINK_W-1:0]   r_blink;
  logic [BLINK_W-1:0]   w_blink_nxt;
  logic                 r_status;
  logic                 w_status_nxt;
  logic                 w_load;
  logic [CNT_W-1:0]     w_load_val;
  logic [CNT_W-1:0]     w_count;
  logic                 w_expired;
  logic                 w_any_open;
  logic                 w_driver_only;

  assign w_any_open    = |doors;
  assign w_driver_only = (doors == NUM_DOORS'(1));

  antitheft_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (one_hz_enable),
    .count    (w_count),
    .expired  (w_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_ARMED;
      r_blink  <= '0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_blink  <= w_blink_nxt;
      r_status <= w_status_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (reprogram) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_any_open)    w_state_nxt = ST_TRIGGERED;
          else if (ignition) w_state_nxt = ST_DISARMED;
        end
        ST_TRIGGERED: begin
          if (ignition)       w_state_nxt = ST_DISARMED;
          else if (w_expired) w_state_nxt = ST_ALARM;
        end
        ST_ALARM: begin
          if (ignition)                       w_state_nxt = ST_DISARMED;
          else if (w_expired && !w_any_open)  w_state_nxt = ST_ARMED;
        end
        ST_DISARMED: begin
          if (!ignition) w_state_nxt = ST_WAIT_OPEN;
        end
        ST_WAIT_OPEN: begin
          if (doors[0])      w_state_nxt = ST_WAIT_CLOSE;
          else if (ignition) w_state_nxt = ST_DISARMED;
        end
        ST_WAIT_CLOSE: begin
          if (!doors[0])     w_state_nxt = ST_WAIT_TIME;
          else if (ignition) w_state_nxt = ST_DISARMED;
        end
        ST_WAIT_TIME: begin
          if (ignition)        w_state_nxt = ST_DISARMED;
          else if (w_any_open) w_state_nxt = ST_WAIT_CLOSE;
          else if (w_expired)  w_state_nxt = ST_ARMED;
        end
        default: w_state_nxt = ST_ARMED;
      endcase
    end
  end

  // Timed states load on entry; untimed states force the counter to 0.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (w_state_nxt)
      ST_TRIGGERED: begin
        if (r_state != ST_TRIGGERED) begin
          w_load     = 1'b1;
          w_load_val = w_driver_only ? CNT_W'(T_DRIVER_DELAY) : CNT_W'(T_PASS_DELAY);
        end
      end
      ST_ALARM: begin
        if ((r_state != ST_ALARM) || w_any_open) begin
          w_load     = 1'b1;
          w_load_val = CNT_W'(T_ALARM_ON);
        end
      end
      ST_WAIT_TIME: begin
        if (r_state != ST_WAIT_TIME) begin
          w_load     = 1'b1;
          w_load_val = CNT_W'(T_ARM_DELAY);
        end
      end
      default: begin
        w_load     = 1'b1;
        w_load_val = '0;
      end
    endcase
  end

  always_comb begin
    w_blink_nxt  = '0;
    w_status_nxt = 1'b0;
    case (w_state_nxt)
      ST_TRIGGERED, ST_ALARM: w_status_nxt = 1'b1;
      ST_ARMED: begin
        if (r_state == ST_ARMED) begin
          w_status_nxt = r_status;
          w_blink_nxt  = r_blink;
          if (one_hz_enable) begin
            if (r_blink == BLINK_LAST) begin
              w_status_nxt = ~r_status;
              w_blink_nxt  = '0;
            end else begin
              w_blink_nxt = r_blink + BLINK_W'(1);
            end
          end
        end
      end
      default: begin
        w_blink_nxt  = '0;
        w_status_nxt = 1'b0;
      end
    endcase
  end

  assign status    = r_status;
  assign siren     = (r_state == ST_ALARM);
  assign state_o   = r_state;
  assign time_left = w_count;

endmodule
